syscall_ctrl: RTL and testbench
===============================

Name: syscall_ctrl

Overview:
- Multi-cycle sequencer for MIPS-style `syscall` in the single-cycle CPU.
- Sits between decode/writeback and the register file write port.
- On `syscall`, it decodes `$v0` (sys_op) and stalls the PC while it runs an output handshake (print int from `$a0`), an input handshake (read int into `$v0`), or a halt (exit).
- Owns the register-file write port while a syscall is in flight.

Parameters:
- SYS_OP_W, 4, width of sys_op; equals `SYS_OP_LENGTH`.
- TIMEOUT, 0, cycles to wait in IN_WAIT before writing 0 to `$v0`; 0 disables the timeout.
- TO_W, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- syscall  in  1  decoded syscall instruction present this cycle
- sys_op  in  SYS_OP_W  `$v0` low bits from the register file
- a0_data  in  32  `$a0` value from the register file
- cpu_reg_write  in  1  writeback enable from the CPU datapath
- cpu_write_addr  in  5  writeback target from the CPU
- cpu_write_data  in  32  writeback data from the CPU
- rf_reg_write  out  1  register file write enable
- rf_write_addr  out  5  register file write address
- rf_write_data  out  32  register file write data
- stall  out  1  hold PC and suppress instruction side effects
- halt  out  1  program exited
- out_valid  out  1  print-int data valid
- out_data  out  32  print-int value
- out_ready  in  1  sink accepts out_data
- in_ready  out  1  controller ready for an input integer
- in_valid  in  1  source presents in_data
- in_data  in  32  input integer

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE; out_valid=0, out_data=0, in_ready=0, halt=0, timeout counter=0. Reset overrides any state, including mid-handshake and HALT. A pending transfer is dropped with no writeback.
- States: IDLE, OUT_WAIT, IN_WAIT, IN_WB, HALT.
- IDLE, syscall=1:
  - sys_op=`SYSCALL_OUTPUT_INT` (1): stall=1 combinationally; latch out_data<=a0_data; out_valid<=1; next state OUT_WAIT.
  - sys_op=`SYSCALL_READ_INT` (5): stall=1; in_ready<=1; counter<=0; next state IN_WAIT.
  - sys_op=`SYSCALL_EXIT` (10): stall=1; halt<=1; next state HALT.
  - Any other sys_op: no-op. stall=0; the instruction retires in one cycle.
- IDLE, syscall=0: stall=0; pass-through rf_*=cpu_*.
- OUT_WAIT:
  - stall=1 until the cycle out_valid&&out_ready. In that cycle stall=0, so the PC advances on that edge; out_valid<=0; next state IDLE.
  - out_data is stable and out_valid is never dropped before acceptance.
- IN_WAIT:
  - stall=1. On in_valid&&in_ready: latch in_data; in_ready<=0; next state IN_WB.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 without a handshake: latch 0; in_ready<=0; next state IN_WB.
  - The counter saturates and does not wrap.
- IN_WB:
  - stall=0; rf_reg_write=1, rf_write_addr=`REG_V0` (2), rf_write_data=latched value. The write and PC advance share the same edge.
  - Next state IDLE.
- HALT: stall=1, halt=1 until reset; syscall ignored.
- Write-port mux:
  - In IN_WB, the controller drives the write port.
  - Otherwise rf_reg_write = cpu_reg_write & ~stall, addr/data = cpu_*.
- syscall is ignored outside IDLE; it is held high by the stalled PC.
- Back-to-back syscalls: the instruction after retirement is decoded normally in IDLE on the next cycle.
- Latency: print takes 1 cycle plus sink wait. Read takes 2 cycles plus source wait. No combinational path from out_ready or in_valid to out_valid or in_ready.

Decomposition:
- Shared header `instruction_head.v` holds:
  - `SYS_OP_LENGTH`, `SYSCALL_OUTPUT_INT`, `SYSCALL_READ_INT`, `SYSCALL_EXIT`
  - `REG_V0`, `REG_A0`
  - state encodings
- Single module; no sub-module needed. The timeout counter stays inline.

Test Plan:
- Print: sys_op=1, a0=0x0000_002A, syscall=1, out_ready held low 3 cycles then high.
  - out_valid=1, out_data=0x2A stable for 4 cycles; stall=1 for 4 cycles, 0 on the accept cycle; then IDLE.
- Read: sys_op=5, in_valid asserted after 2 cycles with in_data=0xDEAD_BEEF.
  - in_ready=1 for 3 cycles; next cycle rf_reg_write=1, addr=2, data=0xDEADBEEF, stall=0.
  - cpu_reg_write=1 is suppressed throughout.
- Timeout: TIMEOUT=4, sys_op=5, in_valid never asserted.
  - After 4 IN_WAIT cycles, IN_WB writes 0 to `$v0`; in_ready falls.
- Exit: sys_op=10 → halt=1 and stall=1 persist 100 cycles; then rst=1 one cycle → halt=0, stall=0, IDLE.
- Reset mid-op: rst=1 during OUT_WAIT and separately during IN_WAIT.
  - out_valid=0, in_ready=0, no rf write; the next syscall works.
- Unknown op / back-to-back: sys_op=7 → stall=0, no handshake.
  - Print immediately followed by print (a0=1 then a0=2): two accepted transfers in order, values 1 then 2.

Source files
------------

// File: rtl/syscall_ctrl_pkg.sv
// rtl/syscall_ctrl_pkg.sv - shared syscall codes, register numbers and sequencer states
// Contents:
//   SYS_OP_LENGTH       width of the $v0 syscall selector
//   SYSCALL_*           syscall service numbers handled by syscall_ctrl
//   REG_V0, REG_A0      MIPS register numbers used by the services
//   sys_state_t         syscall_ctrl state encoding

package syscall_ctrl_pkg;

   localparam int SYS_OP_LENGTH = 4;

   localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_OUTPUT_INT = 4'd1;
   localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_READ_INT   = 4'd5;
   localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_EXIT       = 4'd10;

   localparam logic [4:0] REG_V0 = 5'd2;
   localparam logic [4:0] REG_A0 = 5'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_OUT_WAIT = 3'd1,
      ST_IN_WAIT  = 3'd2,
      ST_IN_WB    = 3'd3,
      ST_HALT     = 3'd4
   } sys_state_t;

endpackage

// File: rtl/syscall_ctrl.sv
// rtl/syscall_ctrl.sv - multi-cycle syscall sequencer owning the register-file write port
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   syscall, sys_op, a0_data         decoded syscall, $v0 selector, $a0 value
//   cpu_reg_write/addr/data          CPU writeback request
//   rf_reg_write/addr/data           register-file write port
//   stall                            hold PC, suppress side effects
//   halt                             program exited
//   out_valid, out_data, out_ready   print-int handshake
//   in_ready, in_valid, in_data      read-int handshake

module syscall_ctrl
   import syscall_ctrl_pkg::*;
#(
   parameter int SYS_OP_W = SYS_OP_LENGTH,
   parameter int TIMEOUT  = 0,
   parameter int TO_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                syscall,
   input  logic [SYS_OP_W-1:0] sys_op,
   input  logic [31:0]         a0_data,
   input  logic                cpu_reg_write,
   input  logic [4:0]          cpu_write_addr,
   input  logic [31:0]         cpu_write_data,
   output logic                rf_reg_write,
   output logic [4:0]          rf_write_addr,
   output logic [31:0]         rf_write_data,
   output logic                stall,
   output logic                halt,
   output logic                out_valid,
   output logic [31:0]         out_data,
   input  logic                out_ready,
   output logic                in_ready,
   input  logic                in_valid,
   input  logic [31:0]         in_data
);

   localparam logic [SYS_OP_W-1:0] OP_PRINT = SYS_OP_W'(SYSCALL_OUTPUT_INT);
   localparam logic [SYS_OP_W-1:0] OP_READ  = SYS_OP_W'(SYSCALL_READ_INT);
   localparam logic [SYS_OP_W-1:0] OP_EXIT  = SYS_OP_W'(SYSCALL_EXIT);

   // Last counter value before the read gives up; unused when TIMEOUT is 0.
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   sys_state_t      state_q, state_d;
   logic [TO_W-1:0] to_cnt_q;
   logic [31:0]     in_value_q;
   logic            accept_out;
   logic            accept_in;
   logic            timeout_hit;

   assign accept_out  = out_valid && out_ready;
   assign accept_in   = in_valid && in_ready;
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (syscall) begin
               if (sys_op == OP_PRINT) begin
                  stall   = 1'b1;
                  state_d = ST_OUT_WAIT;
               end else if (sys_op == OP_READ) begin
                  stall   = 1'b1;
                  state_d = ST_IN_WAIT;
               end else if (sys_op == OP_EXIT) begin
                  stall   = 1'b1;
                  state_d = ST_HALT;
               end
            end
         end
         ST_OUT_WAIT: begin
            // Release the PC on the accept edge so the syscall retires with it.
            stall = !accept_out;
            if (accept_out) begin
               state_d = ST_IDLE;
            end
         end
         ST_IN_WAIT: begin
            stall = 1'b1;
            if (accept_in || timeout_hit) begin
               state_d = ST_IN_WB;
            end
         end
         ST_IN_WB: begin
            state_d = ST_IDLE;
         end
         ST_HALT: begin
            stall = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         in_ready   <= 1'b0;
         halt       <= 1'b0;
         to_cnt_q   <= '0;
         in_value_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (syscall) begin
                  if (sys_op == OP_PRINT) begin
                     out_data  <= a0_data;
                     out_valid <= 1'b1;
                  end else if (sys_op == OP_READ) begin
                     in_ready <= 1'b1;
                     to_cnt_q <= '0;
                  end else if (sys_op == OP_EXIT) begin
                     halt <= 1'b1;
                  end
               end
            end
            ST_OUT_WAIT: begin
               if (accept_out) begin
                  out_valid <= 1'b0;
               end
            end
            ST_IN_WAIT: begin
               // A handshake in the timeout cycle still delivers the real data.
               if (accept_in) begin
                  in_value_q <= in_data;
                  in_ready   <= 1'b0;
               end else if (timeout_hit) begin
                  in_value_q <= '0;
                  in_ready   <= 1'b0;
               end else if (to_cnt_q != '1) begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Register-file write port: controller owns it in IN_WB, otherwise the
   // CPU writeback passes through unless the instruction is stalled.
   always_comb begin
      rf_reg_write  = cpu_reg_write & ~stall;
      rf_write_addr = cpu_write_addr;
      rf_write_data = cpu_write_data;
      if (state_q == ST_IN_WB) begin
         rf_reg_write  = 1'b1;
         rf_write_addr = REG_V0;
         rf_write_data = in_value_q;
      end
   end

endmodule

// File: tb/tb_syscall_ctrl.sv
// tb/tb_syscall_ctrl.sv - randomized self-checking bench for syscall_ctrl

module tb_syscall_ctrl;

   localparam int TB_TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic        syscall;
   logic [3:0]  sys_op;
   logic [31:0] a0_data;
   logic        cpu_reg_write;
   logic [4:0]  cpu_write_addr;
   logic [31:0] cpu_write_data;
   logic        rf_reg_write;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        stall;
   logic        halt;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        in_ready;
   logic        in_valid;
   logic [31:0] in_data;

   int errors = 0;
   int checks = 0;

   syscall_ctrl #(
      .SYS_OP_W (4),
      .TIMEOUT  (TB_TIMEOUT),
      .TO_W     (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .syscall        (syscall),
      .sys_op         (sys_op),
      .a0_data        (a0_data),
      .cpu_reg_write  (cpu_reg_write),
      .cpu_write_addr (cpu_write_addr),
      .cpu_write_data (cpu_write_data),
      .rf_reg_write   (rf_reg_write),
      .rf_write_addr  (rf_write_addr),
      .rf_write_data  (rf_write_data),
      .stall          (stall),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .in_ready       (in_ready),
      .in_valid       (in_valid),
      .in_data        (in_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every task starts and ends just after a falling edge; inputs change
   // there and outputs are sampled 1ns later, far from the rising edge.

   task automatic test_reset();
      rst = 1'b1;
      syscall = 1'b0;
      cpu_reg_write = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b0 ||
          halt !== 1'b0 || stall !== 1'b0 || rf_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL reset: ov=%b od=%h ir=%b halt=%b stall=%b we=%b required all zero",
                  out_valid, out_data, in_ready, halt, stall, rf_reg_write);
      end
      @(negedge clk);
   endtask

   task automatic test_print(input logic [31:0] a0, input int wait_cyc);
      syscall = 1'b1;
      sys_op = 4'd1;
      a0_data = a0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      cpu_reg_write = 1'b1;
      cpu_write_addr = 5'($urandom);
      cpu_write_data = $urandom;
      #1;
      checks++;
      if (stall !== 1'b1 || rf_reg_write !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL print_issue: stall=%b we=%b ov=%b required 1 0 0",
                  stall, rf_reg_write, out_valid);
      end
      @(negedge clk);
      for (int i = 0; i <= wait_cyc; i++) begin
         out_ready = (i == wait_cyc);
         a0_data = $urandom;
         cpu_reg_write = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== a0) begin
            errors++;
            $display("FAIL print_data: ov=%b od=%h required 1 %h", out_valid, out_data, a0);
         end
         checks++;
         if (stall !== (i != wait_cyc) ||
             rf_reg_write !== ((i == wait_cyc) ? cpu_reg_write : 1'b0)) begin
            errors++;
            $display("FAIL print_stall: stall=%b we=%b required %b %b", stall, rf_reg_write,
                     (i != wait_cyc), ((i == wait_cyc) ? cpu_reg_write : 1'b0));
         end
         @(negedge clk);
      end
      syscall = 1'b0;
      out_ready = 1'b0;
      cpu_reg_write = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL print_done: ov=%b stall=%b ir=%b required 0 0 0",
                  out_valid, stall, in_ready);
      end
   endtask

   task automatic test_read(input logic [31:0] data, input int delay);
      int          n;
      logic [31:0] expv;
      // Source delay below TIMEOUT gives the data after delay+1 ready cycles,
      // otherwise the controller gives up after TIMEOUT cycles with 0.
      n    = (delay < TB_TIMEOUT) ? delay + 1 : TB_TIMEOUT;
      expv = (delay < TB_TIMEOUT) ? data : 32'd0;
      syscall = 1'b1;
      sys_op = 4'd5;
      out_ready = 1'b0;
      in_valid = 1'b0;
      cpu_reg_write = 1'b1;
      cpu_write_addr = 5'($urandom);
      #1;
      checks++;
      if (stall !== 1'b1 || rf_reg_write !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL read_issue: stall=%b we=%b ir=%b required 1 0 0",
                  stall, rf_reg_write, in_ready);
      end
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         in_valid = (i == delay);
         in_data = (i == delay) ? data : $urandom;
         #1;
         checks++;
         if (in_ready !== 1'b1 || stall !== 1'b1 || rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL read_wait: ir=%b stall=%b we=%b required 1 1 0",
                     in_ready, stall, rf_reg_write);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      cpu_write_addr = 5'($urandom);
      cpu_write_data = $urandom;
      #1;
      checks++;
      if (rf_reg_write !== 1'b1 || rf_write_addr !== 5'd2 || rf_write_data !== expv ||
          stall !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL read_wb: we=%b addr=%0d data=%h stall=%b ir=%b required 1 2 %h 0 0",
                  rf_reg_write, rf_write_addr, rf_write_data, stall, in_ready, expv);
      end
      @(negedge clk);
      syscall = 1'b0;
      cpu_reg_write = 1'b0;
   endtask

   task automatic test_unknown();
      logic [3:0] op;
      op = 4'($urandom);
      while (op == 4'd1 || op == 4'd5 || op == 4'd10) op = 4'($urandom);
      syscall = 1'b1;
      sys_op = op;
      cpu_reg_write = 1'b1;
      cpu_write_addr = 5'($urandom);
      cpu_write_data = $urandom;
      #1;
      checks++;
      if (stall !== 1'b0 || rf_reg_write !== 1'b1 || rf_write_addr !== cpu_write_addr ||
          rf_write_data !== cpu_write_data) begin
         errors++;
         $display("FAIL unknown_op %0d: stall=%b we=%b addr=%0d data=%h required 0 1 %0d %h",
                  op, stall, rf_reg_write, rf_write_addr, rf_write_data,
                  cpu_write_addr, cpu_write_data);
      end
      @(negedge clk);
      syscall = 1'b0;
      cpu_reg_write = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || halt !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL unknown_after: ov=%b ir=%b halt=%b stall=%b required 0 0 0 0",
                  out_valid, in_ready, halt, stall);
      end
   endtask

   task automatic test_exit();
      int bad;
      bad = 0;
      syscall = 1'b1;
      sys_op = 4'd10;
      #1;
      checks++;
      if (stall !== 1'b1 || halt !== 1'b0) begin
         errors++;
         $display("FAIL exit_issue: stall=%b halt=%b required 1 0", stall, halt);
      end
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         syscall = 1'($urandom);
         sys_op = 4'($urandom);
         cpu_reg_write = 1'b1;
         out_ready = 1'($urandom);
         #1;
         checks++;
         if (halt !== 1'b1 || stall !== 1'b1 || rf_reg_write !== 1'b0 ||
             out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL exit_hold cycle %0d: halt=%b stall=%b we=%b required 1 1 0",
                     i, halt, stall, rf_reg_write);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      syscall = 1'b0;
      cpu_reg_write = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (halt !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL exit_reset: halt=%b stall=%b required 0 0", halt, stall);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      // Reset while a print waits on the sink.
      syscall = 1'b1;
      sys_op = 4'd1;
      a0_data = 32'h1234_5678;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      syscall = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || stall !== 1'b0 || rf_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_print: ov=%b od=%h stall=%b we=%b required 0 0 0 0",
                  out_valid, out_data, stall, rf_reg_write);
      end
      @(negedge clk);
      test_print(32'hCAFE_0001, 1);
      @(negedge clk);
      // Reset while a read waits on the source, with data offered at the reset edge.
      syscall = 1'b1;
      sys_op = 4'd5;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h5555_AAAA;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      syscall = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || stall !== 1'b0 || rf_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_read: ir=%b stall=%b we=%b required 0 0 0",
                  in_ready, stall, rf_reg_write);
      end
      @(negedge clk);
      checks++;
      if (rf_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_read_wb: we=%b required 0", rf_reg_write);
      end
      test_read(32'h0BAD_F00D, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 2))
            0: test_print($urandom, int'($urandom_range(0, 4)));
            1: test_read($urandom, int'($urandom_range(0, 6)));
            default: test_unknown();
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      syscall = 1'b0;
      sys_op = 4'd0;
      a0_data = 32'd0;
      cpu_reg_write = 1'b0;
      cpu_write_addr = 5'd0;
      cpu_write_data = 32'd0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      in_data = 32'd0;
      @(negedge clk);

      test_reset();
      test_print(32'h0000_002A, 3);
      @(negedge clk);
      test_read(32'hDEAD_BEEF, 2);
      @(negedge clk);
      test_read(32'h1111_2222, 100);
      @(negedge clk);
      test_read(32'h3333_4444, TB_TIMEOUT - 1);
      @(negedge clk);
      test_unknown();
      @(negedge clk);
      test_print(32'd1, 0);
      test_print(32'd2, 2);
      @(negedge clk);
      test_reset_mid();
      @(negedge clk);
      test_random();
      @(negedge clk);
      test_exit();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
